// File: rtl/unidade_controle.sv
// unidade_controle: multi-cycle load/store/ALU controller.
// Accepts one instruction at a time through a valid/ready handshake, latches
// its fields, and sequences IDLE -> READ -> EXEC -> (MEM) -> (WB) -> IDLE,
// driving register-file addresses, memory/register write strobes and the
// datapath selects.
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   instr_valid/instr_ready   instruction handshake
//   instr_op/rd/rs1/rs2/imm   instruction fields (op: 000 LD 001 SD 010 ADD 011 SUB)
//   Ra, Rb, Rw                register-file read/write addresses
//   weReg, weMem              register-file / memory write strobes
//   sinal, sinalMux           adder mode, datapath source select
//   C                         sign-extended immediate
//   done, err                 completion / illegal-opcode pulses
//   retired                   count of completed legal instructions (wraps)
module unidade_controle #(
  parameter int REG_AW = 5,
  parameter int IMM_W  = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              instr_valid,
  output logic              instr_ready,
  input  logic [2:0]        instr_op,
  input  logic [REG_AW-1:0] instr_rd,
  input  logic [REG_AW-1:0] instr_rs1,
  input  logic [REG_AW-1:0] instr_rs2,
  input  logic [IMM_W-1:0]  instr_imm,
  output logic [REG_AW-1:0] Ra,
  output logic [REG_AW-1:0] Rb,
  output logic [REG_AW-1:0] Rw,
  output logic              weReg,
  output logic              weMem,
  output logic              sinal,
  output logic              sinalMux,
  output logic [63:0]       C,
  output logic              done,
  output logic              err,
  output logic [15:0]       retired
);
  localparam logic [2:0] OP_LD  = 3'b000;
  localparam logic [2:0] OP_SD  = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b011;

  typedef enum logic [2:0] {IDLE, READ, EXEC, MEM, WB} state_t;

  state_t     state;
  logic [2:0] op_q;

  // Ready is combinational so a back-to-back instruction is taken in the
  // very cycle the FSM lands in IDLE.
  assign instr_ready = (state == IDLE) && !rst;

  // Strobes and done are registered: they are set on the edge that enters
  // the state they belong to, so they are high exactly during that state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      op_q     <= OP_LD;
      Ra       <= '0;
      Rb       <= '0;
      Rw       <= '0;
      C        <= '0;
      sinal    <= 1'b0;
      sinalMux <= 1'b0;
      weReg    <= 1'b0;
      weMem    <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
      retired  <= '0;
    end else begin
      weReg <= 1'b0;
      weMem <= 1'b0;
      done  <= 1'b0;
      err   <= 1'b0;
      unique case (state)
        IDLE: begin
          if (instr_valid) begin
            op_q     <= instr_op;
            Ra       <= instr_rs1;
            Rb       <= instr_rs2;
            Rw       <= instr_rd;
            C        <= {{(64-IMM_W){instr_imm[IMM_W-1]}}, instr_imm};
            sinal    <= (instr_op == OP_SUB);
            sinalMux <= (instr_op == OP_ADD) || (instr_op == OP_SUB);
            // Illegal opcodes are swallowed here; the FSM never leaves IDLE.
            if (instr_op[2] == 1'b0) state <= READ;
            else                     err   <= 1'b1;
          end
        end
        READ: state <= EXEC;
        EXEC: begin
          if (op_q == OP_LD) begin
            state <= MEM;
          end else if (op_q == OP_SD) begin
            // SD finishes in MEM: write strobe and completion together.
            state   <= MEM;
            weMem   <= 1'b1;
            done    <= 1'b1;
            retired <= retired + 16'd1;
          end else begin
            state   <= WB;
            weReg   <= (Rw != '0);
            done    <= 1'b1;
            retired <= retired + 16'd1;
          end
        end
        MEM: begin
          if (op_q == OP_LD) begin
            state   <= WB;
            weReg   <= (Rw != '0);
            done    <= 1'b1;
            retired <= retired + 16'd1;
          end else begin
            state <= IDLE;
          end
        end
        WB:      state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_unidade_controle.sv
module tb_unidade_controle;
  logic        clk = 1'b0;
  logic        rst;
  logic        instr_valid;
  logic        instr_ready;
  logic [2:0]  instr_op;
  logic [4:0]  instr_rd, instr_rs1, instr_rs2;
  logic [11:0] instr_imm;
  logic [4:0]  Ra, Rb, Rw;
  logic        weReg, weMem, sinal, sinalMux, done, err;
  logic [63:0] C;
  logic [15:0] retired;

  unidade_controle #(.REG_AW(5), .IMM_W(12)) dut (
    .clk(clk), .rst(rst),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr_op(instr_op), .instr_rd(instr_rd), .instr_rs1(instr_rs1),
    .instr_rs2(instr_rs2), .instr_imm(instr_imm),
    .Ra(Ra), .Rb(Rb), .Rw(Rw), .weReg(weReg), .weMem(weMem),
    .sinal(sinal), .sinalMux(sinalMux), .C(C),
    .done(done), .err(err), .retired(retired)
  );

  always #5 clk = ~clk;

  localparam logic [2:0] LD = 3'b000, SD = 3'b001, ADD = 3'b010, SUB = 3'b011;

  typedef struct {
    int unsigned due;
    logic        we_reg;
    logic        we_mem;
    logic [4:0]  rw;
    logic [15:0] ret;
  } exp_t;

  exp_t        sb[$];
  int unsigned cyc = 0;
  int          checks = 0;
  int          errors = 0;
  int          n_wereg = 0, n_wemem = 0;
  int          exp_wereg = 0, exp_wemem = 0;
  logic [15:0] exp_ret = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Completion monitor: every done pulse must match the oldest outstanding
  // instruction's expected cycle, strobes and retired count.
  always @(negedge clk) begin : mon
    exp_t e;
    if (!rst) begin
      if (weReg) n_wereg <= n_wereg + 1;
      if (weMem) n_wemem <= n_wemem + 1;
      if (done) begin
        if (sb.size() == 0) chk("done_unexpected", 1, 0);
        else begin
          e = sb.pop_front();
          chk("done_cycle", cyc, e.due);
          chk("done_weReg", weReg, e.we_reg);
          chk("done_weMem", weMem, e.we_mem);
          chk("done_retired", retired, e.ret);
          if (e.we_reg) chk("done_Rw", Rw, e.rw);
        end
      end
    end
  end

  // Drive an instruction, hold it until accepted, push its expectation.
  // Returns at the negedge after the accept edge, with valid dropped.
  task automatic issue(input logic [2:0] op, input logic [4:0] rd, rs1, rs2,
                       input logic [11:0] imm, output int unsigned acc);
    int n;
    exp_t e;
    instr_valid = 1'b1; instr_op = op; instr_rd = rd;
    instr_rs1 = rs1; instr_rs2 = rs2; instr_imm = imm;
    n = 0;
    while (!instr_ready && n < 40) begin @(negedge clk); n++; end
    if (!instr_ready) chk("accept_timeout", 0, 1);
    acc = cyc;
    if (op[2] == 1'b0) begin
      exp_ret  = exp_ret + 16'd1;
      e.due    = acc + ((op == LD) ? 4 : 3);
      e.we_reg = (op != SD) && (rd != 0);
      e.we_mem = (op == SD);
      e.rw     = rd;
      e.ret    = exp_ret;
      sb.push_back(e);
      if (e.we_reg) exp_wereg++;
      if (e.we_mem) exp_wemem++;
    end
    @(negedge clk);
    instr_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (!instr_ready && n < 40) begin @(negedge clk); n++; end
    if (!instr_ready) chk("idle_timeout", 0, 1);
  endtask

  initial begin
    int unsigned a0, a1;
    rst = 1'b1; instr_valid = 1'b0; instr_op = '0; instr_rd = '0;
    instr_rs1 = '0; instr_rs2 = '0; instr_imm = '0;
    repeat (3) @(negedge clk);
    chk("reset_outputs", {instr_ready, weReg, weMem, done, err, Ra, Rb, Rw,
                          sinal, sinalMux, C, retired}, '0);
    rst = 1'b0;
    #1;
    chk("ready_after_reset", instr_ready, 1);

    // LD r1, 8(r0)
    issue(LD, 5'd1, 5'd0, 5'd0, 12'd8, a0);
    chk("ld_ready_low", instr_ready, 0);
    chk("ld_Ra", Ra, 0);
    chk("ld_C", C, 64'd8);
    chk("ld_sinalMux", sinalMux, 0);
    wait_idle();
    chk("ld_retired", retired, 1);

    // ADD then SUB, SUB presented while ADD is still busy
    issue(ADD, 5'd3, 5'd2, 5'd1, 12'd0, a0);
    chk("add_sinal", sinal, 0);
    chk("add_sinalMux", sinalMux, 1);
    chk("add_Ra_Rb", {Ra, Rb}, {5'd2, 5'd1});
    issue(SUB, 5'd4, 5'd3, 5'd1, 12'd0, a1);
    chk("sub_back_to_back", a1 - a0, 4);
    chk("sub_sinal", sinal, 1);
    chk("sub_sinalMux", sinalMux, 1);
    chk("sub_Rw", Rw, 4);
    wait_idle();
    chk("addsub_retired", retired, 3);

    // SD r6, -4(r5)
    issue(SD, 5'd0, 5'd5, 5'd6, 12'hFFC, a0);
    chk("sd_C", C, 64'hFFFF_FFFF_FFFF_FFFC);
    chk("sd_Ra_Rb", {Ra, Rb}, {5'd5, 5'd6});
    chk("sd_sinalMux", sinalMux, 0);
    wait_idle();

    // ADD to r0: completes without a register write
    issue(ADD, 5'd0, 5'd1, 5'd2, 12'd0, a0);
    wait_idle();
    chk("add_r0_retired", retired, exp_ret);

    // Illegal opcode
    issue(3'b111, 5'd9, 5'd9, 5'd9, 12'd0, a0);
    chk("illegal_err", err, 1);
    chk("illegal_ready", instr_ready, 1);
    @(negedge clk);
    chk("illegal_err_once", err, 0);
    chk("illegal_retired", retired, exp_ret);

    // Reset while an LD sits in MEM
    issue(LD, 5'd2, 5'd3, 5'd0, 12'd16, a0);
    @(negedge clk);
    @(negedge clk);
    chk("mem_no_strobe", {weReg, done}, 2'b00);
    rst = 1'b1;
    void'(sb.pop_back());
    exp_wereg--;
    exp_ret = '0;
    @(negedge clk);
    chk("abort_outputs", {instr_ready, weReg, weMem, done, err, Ra, Rb, Rw,
                          sinal, sinalMux, C, retired}, '0);
    rst = 1'b0;
    repeat (6) @(negedge clk);
    chk("abort_idle_ready", instr_ready, 1);

    // retired wrap: preload 0xFFFF, next completion gives 0x0000
    force dut.retired = 16'hFFFF;
    @(negedge clk);
    release dut.retired;
    @(negedge clk);
    chk("preload_retired", retired, 16'hFFFF);
    exp_ret = 16'hFFFF;
    issue(ADD, 5'd7, 5'd1, 5'd2, 12'd0, a0);
    wait_idle();
    chk("wrap_retired", retired, 16'h0000);

    @(negedge clk);
    chk("weReg_pulses", n_wereg, exp_wereg);
    chk("weMem_pulses", n_wemem, exp_wemem);
    chk("scoreboard_empty", sb.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end
endmodule
